// File: rtl/irrigation_pkg.sv
// Shared definitions for the irrigation condition decoder.
//   - Condition code values carried on {bit1, bit0}.
//   - FSM state encoding used by the top-level valve sequencer.
package irrigation_pkg;

  localparam logic [1:0] CODE_OFF       = 2'b00;
  localparam logic [1:0] CODE_SPRINKLER = 2'b01;
  localparam logic [1:0] CODE_DRIP      = 2'b10;
  localparam logic [1:0] CODE_RESERVED  = 2'b11;

  typedef enum logic [1:0] {
    ST_OFF       = 2'b00,
    ST_SPRINKLER = 2'b01,
    ST_DRIP      = 2'b10,
    ST_DEAD      = 2'b11
  } state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/irrigation_condition_decoder_code_debouncer.sv
// code_debouncer: accepts a 2-bit raw code once it has been sampled identically
// on STABLE_CYCLES consecutive rising edges.
// Ports:
//   clk_i            in  1  system clock
//   reset_i          in  1  synchronous active-high reset (candidate, count, accepted -> 0)
//   raw_code_i       in  2  unfiltered code
//   accepted_code_o  out 2  filtered (accepted) code, registered
module code_debouncer
  import irrigation_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [1:0] raw_code_i,
  output logic [1:0] accepted_code_o
);

  localparam int CNT_W = $clog2(STABLE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] STABLE_N = CNT_W'(STABLE_CYCLES);

  logic [1:0]       cand_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [1:0]       accepted_q;

  // A differing sample starts a new run of length one; a repeat extends the
  // run, saturating once the threshold is reached so the count never wraps.
  always_comb begin
    cnt_d = cnt_q;
    if (raw_code_i != cand_q) begin
      cnt_d = CNT_W'(1);
    end else if (cnt_q < STABLE_N) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cand_q     <= CODE_OFF;
      cnt_q      <= '0;
      accepted_q <= CODE_OFF;
    end else begin
      cand_q <= raw_code_i;
      cnt_q  <= cnt_d;
      if (cnt_d >= STABLE_N) begin
        accepted_q <= raw_code_i;
      end
    end
  end

  assign accepted_code_o = accepted_q;

endmodule

// File: rtl/irrigation_condition_decoder.sv
// irrigation_condition_decoder: filters the 2-bit condition code and sequences
// the sprinkler / drip valves with break-before-make, minimum on-time and dead-time.
// Ports:
//   clk_i              in  1  system clock
//   reset_i            in  1  synchronous active-high reset
//   bit0_i, bit1_i     in  1  condition code {bit1, bit0}
//   sprinkler_valve_o  out 1  sprinkler drive (registered)
//   drip_valve_o       out 1  drip drive (registered)
//   active_code_o      out 2  accepted code
//   busy_o             out 1  requested change held off by min-on or dead-time
//   fault_o            out 1  accepted code is reserved (11)
module irrigation_condition_decoder
  import irrigation_pkg::*;
#(
  parameter int STABLE_CYCLES   = 4,
  parameter int DEADTIME_CYCLES = 8,
  parameter int MIN_ON_CYCLES   = 16
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       bit0_i,
  input  logic       bit1_i,
  output logic       sprinkler_valve_o,
  output logic       drip_valve_o,
  output logic [1:0] active_code_o,
  output logic       busy_o,
  output logic       fault_o
);

  localparam int MAX_P = max3(STABLE_CYCLES, DEADTIME_CYCLES, MIN_ON_CYCLES);
  localparam int CNT_W = $clog2(MAX_P) + 1;
  localparam logic [CNT_W-1:0] MIN_ON_N    = CNT_W'(MIN_ON_CYCLES);
  localparam logic [CNT_W-1:0] MIN_ON_LAST = CNT_W'(MIN_ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] DEAD_LOAD   = CNT_W'(DEADTIME_CYCLES - 1);

  logic [1:0]       accepted;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] on_cnt_q, on_cnt_d;
  logic [CNT_W-1:0] dead_cnt_q, dead_cnt_d;
  logic [1:0]       own_code;
  logic             valve_state;
  logic             sprinkler_q, drip_q;

  code_debouncer #(
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_debouncer (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .raw_code_i     ({bit1_i, bit0_i}),
    .accepted_code_o(accepted)
  );

  assign valve_state = (state_q == ST_SPRINKLER) || (state_q == ST_DRIP);
  assign own_code    = (state_q == ST_SPRINKLER) ? CODE_SPRINKLER : CODE_DRIP;

  always_comb begin
    state_d    = state_q;
    on_cnt_d   = on_cnt_q;
    dead_cnt_d = dead_cnt_q;
    case (state_q)
      ST_OFF: begin
        on_cnt_d = '0;
        if (accepted == CODE_SPRINKLER) begin
          state_d = ST_SPRINKLER;
        end else if (accepted == CODE_DRIP) begin
          state_d = ST_DRIP;
        end
      end
      ST_SPRINKLER, ST_DRIP: begin
        // on_cnt equals cycles already spent in the state, so reaching
        // MIN_ON-1 here means this is the last required on-cycle.
        if ((accepted != own_code) && (on_cnt_q >= MIN_ON_LAST)) begin
          state_d    = ST_DEAD;
          dead_cnt_d = DEAD_LOAD;
          on_cnt_d   = '0;
        end else if (on_cnt_q < MIN_ON_N) begin
          on_cnt_d = on_cnt_q + CNT_W'(1);
        end
      end
      ST_DEAD: begin
        // Only the code present at exit decides the next state.
        if (dead_cnt_q == '0) begin
          on_cnt_d = '0;
          if (accepted == CODE_SPRINKLER) begin
            state_d = ST_SPRINKLER;
          end else if (accepted == CODE_DRIP) begin
            state_d = ST_DRIP;
          end else begin
            state_d = ST_OFF;
          end
        end else begin
          dead_cnt_d = dead_cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_OFF;
      end
    endcase
  end

  // Valve drives come straight from flops so the drivers never see decode glitches.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= ST_OFF;
      on_cnt_q    <= '0;
      dead_cnt_q  <= '0;
      sprinkler_q <= 1'b0;
      drip_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      on_cnt_q    <= on_cnt_d;
      dead_cnt_q  <= dead_cnt_d;
      sprinkler_q <= (state_d == ST_SPRINKLER);
      drip_q      <= (state_d == ST_DRIP);
    end
  end

  assign sprinkler_valve_o = sprinkler_q;
  assign drip_valve_o      = drip_q;
  assign active_code_o     = accepted;
  assign fault_o           = (accepted == CODE_RESERVED);
  assign busy_o            = (state_q == ST_DEAD) ||
                             (valve_state && (accepted != own_code) && (on_cnt_q < MIN_ON_LAST));

endmodule

// File: tb/tb_irrigation_condition_decoder.sv
// Bench for irrigation_condition_decoder: directed scenarios plus random code
// sequences, all compared every cycle against a cycle-time reference model.
module tb_irrigation_condition_decoder;

  localparam int STABLE = 4;
  localparam int DEAD   = 8;
  localparam int MIN_ON = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       bit0 = 1'b0;
  logic       bit1 = 1'b0;
  logic       spr, drip, busy, fault;
  logic [1:0] active;

  int total = 0;
  int bad   = 0;

  // Reference model state: mode 0=off 1=sprinkler 2=drip 3=dead
  int         m_mode    = 0;
  int         m_entered = 0;
  int         t         = 0;
  logic [1:0] m_acc     = 2'b00;
  logic [1:0] hist[$];

  irrigation_condition_decoder #(
    .STABLE_CYCLES  (STABLE),
    .DEADTIME_CYCLES(DEAD),
    .MIN_ON_CYCLES  (MIN_ON)
  ) dut (
    .clk_i            (clk),
    .reset_i          (reset),
    .bit0_i           (bit0),
    .bit1_i           (bit1),
    .sprinkler_valve_o(spr),
    .drip_valve_o     (drip),
    .active_code_o    (active),
    .busy_o           (busy),
    .fault_o          (fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic model_edge(input logic [1:0] code, input logic rst);
    bit same;
    t++;
    if (rst) begin
      m_mode = 0;
      m_acc = 2'b00;
      hist.delete();
      m_entered = t;
    end else begin
      // FSM reacts to the code accepted before this edge
      case (m_mode)
        0: if (m_acc == 2'd1 || m_acc == 2'd2) begin
             m_mode = int'(m_acc);
             m_entered = t;
           end
        1, 2: if (int'(m_acc) != m_mode && (t - m_entered) >= MIN_ON) begin
             m_mode = 3;
             m_entered = t;
           end
        default: if ((t - m_entered) >= DEAD) begin
             m_mode = (m_acc == 2'd1 || m_acc == 2'd2) ? int'(m_acc) : 0;
             m_entered = t;
           end
      endcase
      hist.push_back(code);
      if (hist.size() > STABLE) void'(hist.pop_front());
      if (hist.size() == STABLE) begin
        same = 1'b1;
        foreach (hist[i]) if (hist[i] != code) same = 1'b0;
        if (same) m_acc = code;
      end
    end
  endtask

  task automatic tick(input logic [1:0] code, input logic rst);
    logic exp_busy;
    @(negedge clk);
    bit0  = code[0];
    bit1  = code[1];
    reset = rst;
    @(posedge clk);
    model_edge(code, rst);
    #1;
    exp_busy = (m_mode == 3) ||
               ((m_mode == 1 || m_mode == 2) && int'(m_acc) != m_mode &&
                (t + 1 - m_entered) < MIN_ON);
    check("sprinkler", 32'(spr), 32'(m_mode == 1));
    check("drip", 32'(drip), 32'(m_mode == 2));
    check("active_code", 32'(active), 32'(m_acc));
    check("fault", 32'(fault), 32'(m_acc == 2'b11));
    check("busy", 32'(busy), 32'(exp_busy));
    check("valve_exclusive", 32'(spr & drip), 32'(0));
  endtask

  task automatic hold(input logic [1:0] code, input int n);
    for (int i = 0; i < n; i++) tick(code, 1'b0);
  endtask

  initial begin
    int  rise;
    int  n;
    int  zeros;
    int  on_len;
    bit  any_valve;

    // 1: reset state and first-open latency
    tick(2'b01, 1'b1);
    check("reset_outputs", 32'({spr, drip, active, busy, fault}), 32'(0));
    rise = 0;
    for (int i = 1; i <= 12; i++) begin
      tick(2'b01, 1'b0);
      if (spr && rise == 0) rise = i;
    end
    check("t1_open_edge", 32'(rise), 32'(5));
    check("t1_active", 32'(active), 32'(1));

    // 2: short glitch never accepted
    tick(2'b00, 1'b1);
    any_valve = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(2'b01, 1'b0);
      if (spr || drip || active != 2'b00) any_valve = 1'b1;
    end
    for (int i = 0; i < 20; i++) begin
      tick(2'b00, 1'b0);
      if (spr || drip || active != 2'b00) any_valve = 1'b1;
    end
    check("t2_no_valve", 32'(any_valve), 32'(0));

    // 3: sprinkler -> drip with dead-time
    hold(2'b01, 5);
    hold(2'b01, 40);
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      tick(2'b10, 1'b0);
      if (!spr) begin n = i; break; end
    end
    check("t3_drop_edge", 32'(n), 32'(5));
    zeros = 1;
    for (int i = 0; i < 40; i++) begin
      tick(2'b10, 1'b0);
      if (drip || spr) break;
      zeros++;
    end
    check("t3_dead_len", 32'(zeros), 32'(DEAD));
    check("t3_drip_on", 32'(drip), 32'(1));

    // 4: min-on enforced after a quick revert to off
    tick(2'b00, 1'b1);
    hold(2'b01, 5);
    on_len = 1;
    tick(2'b01, 1'b0);
    if (spr) on_len++;
    for (int i = 0; i < 40; i++) begin
      tick(2'b00, 1'b0);
      if (!spr) break;
      on_len++;
    end
    check("t4_on_len", 32'(on_len), 32'(MIN_ON));
    check("t4_dead_busy", 32'(busy), 32'(1));
    hold(2'b00, DEAD);
    check("t4_off_idle", 32'({spr, drip, busy}), 32'(0));

    // 5: reserved code raises fault
    tick(2'b00, 1'b1);
    hold(2'b11, 3);
    check("t5_fault_early", 32'(fault), 32'(0));
    tick(2'b11, 1'b0);
    check("t5_fault_set", 32'(fault), 32'(1));
    hold(2'b11, 10);
    hold(2'b00, 4);
    check("t5_fault_clear", 32'(fault), 32'(0));

    // 6: reset mid-DEAD and mid-DRIP
    hold(2'b01, 5 + MIN_ON);
    hold(2'b00, 7);
    check("t6_in_dead", 32'(busy), 32'(1));
    tick(2'b10, 1'b1);
    check("t6_reset_dead", 32'({spr, drip, active, busy, fault}), 32'(0));
    rise = 0;
    for (int i = 1; i <= 10; i++) begin
      tick(2'b10, 1'b0);
      if (drip && rise == 0) rise = i;
    end
    check("t6_reopen_edge", 32'(rise), 32'(5));
    tick(2'b10, 1'b1);
    check("t6_reset_drip", 32'({spr, drip, active, busy, fault}), 32'(0));

    // Random code sequences with occasional resets
    for (int s = 0; s < 250; s++) begin
      if ($urandom_range(0, 39) == 0) tick(2'($urandom_range(0, 3)), 1'b1);
      hold(2'($urandom_range(0, 3)), int'($urandom_range(1, 30)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
